regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the ARM single-cycle and upcoming pipelined datapaths: configurable data width, depth and read-port count, two write ports with fixed priority, and a hardwired zero register at the top index. After reset, a sequential init engine preloads every register with its own index, one register per cycle, and signals completion on `ready`. An optional write-to-read bypass is compiled in for the pipelined core.

## Interface
Parameters:
- `WIDTH`, 64, data width in bits.
- `DEPTH`, 32, number of architectural registers (≥ 2, power of two); index `DEPTH-1` is the zero register (XZR).
- `NREAD`, 2, number of read ports (1..4).
- `AW`, `$clog2(DEPTH)`, address width (derived, not overridden).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ra`  in  NREAD*AW  read addresses; port p at bits [p*AW +: AW].
- `rd`  out  NREAD*WIDTH  read data; port p at bits [p*WIDTH +: WIDTH].
- `we0`, `wa0`, `wd0`  in  1 / AW / WIDTH  write port 0 (ALU writeback).
- `we1`, `wa1`, `wd1`  in  1 / AW / WIDTH  write port 1 (memory writeback; higher priority).
- `ready`  out  1  init complete; writes are accepted.
- `wr_drop`  out  1  registered pulse: a write request was discarded in the previous cycle.

## Operation
- FSM states: INIT, RUN. `reset` high forces INIT, `cnt`=0, `ready`=0, `wr_drop`=0; the array is not written while `reset` is high.
- INIT: each edge with `reset` low writes `reg[cnt] <= cnt` (zero-extended to WIDTH) and increments `cnt`. On the edge that writes index `DEPTH-2`, the FSM moves to RUN. `ready` is registered and equals (state == RUN).
- RUN: on each edge, port 0 writes `reg[wa0] <= wd0` if `we0`; port 1 writes `reg[wa1] <= wd1` if `we1`. When both ports target the same address, port 1 wins and port 0 is dropped.
- Writes to address `DEPTH-1` are always ignored; this case is not a drop.
- Drop events set `wr_drop`=1 on the next edge, otherwise `wr_drop`=0. A drop is any of the following:
  - `we0`/`we1` asserted while in INIT with `reset` low.
  - A port-0 write lost to a port-1 write on the same address, excluding XZR.
- Reads are combinational:
  - `rd[p]` = 0 when `ra[p]` == `DEPTH-1`.
  - `rd[p]` = 0 when `ready`=0.
  - Otherwise `rd[p]` = `reg[ra[p]]`, subject to the bypass described under Configuration.
- A reset asserted mid-INIT or during RUN restarts init from `cnt`=0. Previously written contents are overwritten as init proceeds.

## Timing
- Read latency: 0 cycles (combinational). Write latency: 1 edge; the new value is visible the cycle after the write edge.
- `ready` rises exactly `DEPTH-1` rising edges after the first edge with `reset` low (31 for the default).
- `wr_drop` is a single-cycle pulse, aligned to the cycle after the offending request.
- All outputs are 0 in the cycle following a reset edge.

## Configuration
- `REGFILE_BYPASS_EN` defined: in RUN, if `rd` port p's address matches an enabled, non-XZR write in the same cycle, `rd[p]` returns the incoming write data. Port 1 data takes precedence when both ports match.
- `REGFILE_BYPASS_EN` undefined: `rd[p]` returns the stored (pre-edge) value. The write becomes visible the next cycle.

## Test plan
- Reset for 2 cycles, release; sample `ready` each cycle → `ready`=0 for 30 cycles and 1 at cycle 31. Then read r0..r31 → r0..r30 = index value, r31 = 0.
- In RUN, `we0`=1, `wa0`=5, `wd0`=64'hDEAD_BEEF → next cycle `rd0` at `ra`=5 reads 64'hDEAD_BEEF. Same-cycle read:
  - With `REGFILE_BYPASS_EN`: returns 64'hDEAD_BEEF.
  - Without it: returns 5.
- Both ports write address 7 (`wd0`=64'h1111, `wd1`=64'h2222) → r7 = 64'h2222, and `wr_drop`=1 for exactly one cycle.
- Write 64'hFFFF to address 31 via either port → `rd` for address 31 stays 0 and `wr_drop` stays 0.
- `we0`=1 to address 3 at cycle 10 of INIT → `wr_drop` pulses the next cycle. After `ready`, r3 = 3.
- Write r4 = 64'hAB in RUN, assert `reset` for 1 cycle → `ready`=0 and `rd`=0 immediately. After 31 cycles r4 = 4.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, zero register at DEPTH-1,
// index-preloading init engine after reset. Optional bypass via `REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned NREAD = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  input  logic                   we0,
  input  logic [AW-1:0]          wa0,
  input  logic [WIDTH-1:0]       wd0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd1,
  output logic                   ready,
  output logic                   wr_drop
);

  localparam logic [AW-1:0] XZR       = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_INIT = AW'(DEPTH - 2);

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port A carries init data or port 1; port B carries port 0.
  logic             wa_en_c, wb_en_c;
  logic [AW-1:0]    wa_addr_c;
  logic [WIDTH-1:0] wa_data_c;
  logic             w0_ok_c, w1_ok_c, collide_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    wr_drop_d = 1'b0;
    wa_en_c   = 1'b0;
    wb_en_c   = 1'b0;
    wa_addr_c = wa1;
    wa_data_c = wd1;
    w0_ok_c   = !reset && we0 && (wa0 != XZR);
    w1_ok_c   = !reset && we1 && (wa1 != XZR);
    collide_c = w0_ok_c && w1_ok_c && (wa0 == wa1);
    if (reset) begin
      state_d = INIT;
      cnt_d   = '0;
      ready_d = 1'b0;
    end else if (state_q == INIT) begin
      wa_en_c   = 1'b1;
      wa_addr_c = cnt_q;
      wa_data_c = WIDTH'(cnt_q);
      cnt_d     = cnt_q + AW'(1);
      wr_drop_d = we0 | we1;
      if (cnt_q == LAST_INIT) begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end else begin
      wa_en_c   = w1_ok_c;
      wb_en_c   = w0_ok_c && !collide_c;
      wr_drop_d = collide_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage has no reset; reads are gated by ready until init has filled it.
  always_ff @(posedge clk) begin
    if (wa_en_c) mem_q[wa_addr_c] <= wa_data_c;
    if (wb_en_c) mem_q[wa0]       <= wd0;
  end

  always_comb begin
    rd = '0;
    for (int p = 0; p < NREAD; p++) begin
      if (ready_q && (ra[p*AW +: AW] != XZR)) begin
        rd[p*WIDTH +: WIDTH] = mem_q[ra[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (w0_ok_c && (wa0 == ra[p*AW +: AW])) rd[p*WIDTH +: WIDTH] = wd0;
        if (w1_ok_c && (wa1 == ra[p*AW +: AW])) rd[p*WIDTH +: WIDTH] = wd1;
`endif
      end
    end
  end

  assign ready   = ready_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters): directed sequences,
// a write/read vector table and randomized traffic against a reference model.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   ra;
  logic [127:0] rd;
  logic         we0, we1;
  logic [4:0]   wa0, wa1;
  logic [63:0]  wd0, wd1;
  logic         ready, wr_drop;

  regfile_mp dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ready(ready), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register contents, init progress, ready and drop flag.
  logic [63:0] mdl [32];
  int          m_icnt;
  logic        m_ready;
  logic        m_drop;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] exp0;
    logic [63:0] exp1;
    logic        exp_drop;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    logic [63:0] v;
    if (!m_ready || a == 5'd31) return 64'd0;
    v = mdl[a];
`ifdef REGFILE_BYPASS_EN
    if (!reset && we0 && wa0 != 5'd31 && wa0 == a) v = wd0;
    if (!reset && we1 && wa1 != 5'd31 && wa1 == a) v = wd1;
`endif
    return v;
  endfunction

  // Apply the effect of one rising edge with the currently driven inputs.
  task automatic model_edge();
    if (reset) begin
      m_ready = 1'b0;
      m_icnt  = 0;
      m_drop  = 1'b0;
    end else if (!m_ready) begin
      mdl[m_icnt] = 64'(m_icnt);
      m_icnt++;
      m_drop = we0 | we1;
      if (m_icnt == 31) m_ready = 1'b1;
    end else begin
      m_drop = we0 && we1 && (wa0 == wa1) && (wa0 != 5'd31);
      if (we0 && wa0 != 5'd31) mdl[wa0] = wd0;
      if (we1 && wa1 != 5'd31) mdl[wa1] = wd1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    check("ready", ready, m_ready);
    check("wr_drop", wr_drop, m_drop);
    check("rd0", rd[63:0], exp_rd(ra[4:0]));
    check("rd1", rd[127:64], exp_rd(ra[9:5]));
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = 5'd0; wd0 = 64'd0;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 64'd0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF, 1'b0, 5'd0,  64'd0,      5'd5,  5'd31, 64'hDEAD_BEEF, 64'd0,   1'b0};
    tbl[1] = '{1'b1, 5'd7,  64'h1111,      1'b1, 5'd7,  64'h2222,   5'd7,  5'd7,  64'h2222,      64'h2222, 1'b1};
    tbl[2] = '{1'b1, 5'd31, 64'hFFFF,      1'b0, 5'd0,  64'd0,      5'd31, 5'd7,  64'd0,         64'h2222, 1'b0};
    tbl[3] = '{1'b0, 5'd0,  64'd0,         1'b1, 5'd31, 64'hFFFF,   5'd31, 5'd5,  64'd0,         64'hDEAD_BEEF, 1'b0};
    tbl[4] = '{1'b1, 5'd31, 64'hFFFF,      1'b1, 5'd31, 64'hFFFF,   5'd31, 5'd31, 64'd0,         64'd0,   1'b0};
    tbl[5] = '{1'b1, 5'd9,  64'hAAAA,      1'b1, 5'd10, 64'hBBBB,   5'd9,  5'd10, 64'hAAAA,      64'hBBBB, 1'b0};
    tbl[6] = '{1'b0, 5'd12, 64'h5A5A,      1'b0, 5'd12, 64'hA5A5,   5'd12, 5'd0,  64'd12,        64'd0,   1'b0};

    m_ready = 1'b0; m_icnt = 0; m_drop = 1'b0;
    idle();
    ra    = 10'd0;
    reset = 1'b1;
    #1;
    tick();
    tick();
    check_all();
    check("rst_ready", ready, 1'b0);

    // Init: ready timing, drop on a write request at init edge 10.
    reset = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      if (i == 10) begin we0 = 1'b1; wa0 = 5'd3; wd0 = 64'hFFFF; end
      else idle();
      tick();
      check("ready_rise", ready, logic'(i == 31));
      if (i == 10) check("init_drop", wr_drop, 1'b1);
      if (i == 11) check("init_drop_end", wr_drop, 1'b0);
      check_all();
    end
    idle();

    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      #1;
      check("init_val0", rd[63:0], (a == 31) ? 64'd0 : 64'(a));
      check("init_val1", rd[127:64], (a == 0) ? 64'd0 : 64'(31 - a));
    end

    // Same-cycle read of a register being written.
    ra  = {5'd31, 5'd5};
    we0 = 1'b1; wa0 = 5'd5; wd0 = 64'hDEAD_BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle", rd[63:0], 64'hDEAD_BEEF);
`else
    check("same_cycle", rd[63:0], 64'd5);
`endif
    tick();
    idle();
    #1;
    check("after_write", rd[63:0], 64'hDEAD_BEEF);

    // Table: one write cycle, then idle read of the results.
    for (int k = 0; k < 7; k++) begin
      we0 = tbl[k].we0; wa0 = tbl[k].wa0; wd0 = tbl[k].wd0;
      we1 = tbl[k].we1; wa1 = tbl[k].wa1; wd1 = tbl[k].wd1;
      ra  = {tbl[k].ra1, tbl[k].ra0};
      #1;
      check_all();
      tick();
      idle();
      #1;
      check("tbl_rd0", rd[63:0], tbl[k].exp0);
      check("tbl_rd1", rd[127:64], tbl[k].exp1);
      check("tbl_drop", wr_drop, tbl[k].exp_drop);
    end

    // Reset during RUN restarts init and restores r4 to its index.
    we0 = 1'b1; wa0 = 5'd4; wd0 = 64'hAB;
    tick();
    idle();
    ra = {5'd31, 5'd4};
    #1;
    check("r4_written", rd[63:0], 64'hAB);
    reset = 1'b1;
    tick();
    check("rst_run_ready", ready, 1'b0);
    check("rst_run_rd", rd[63:0], 64'd0);
    check("rst_run_drop", wr_drop, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      check("re_init_ready", ready, logic'(i == 31));
    end
    check("r4_restored", rd[63:0], 64'd4);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      we0 = 1'($urandom); wa0 = 5'($urandom); wd0 = {$urandom, $urandom};
      we1 = 1'($urandom); wa1 = 5'($urandom); wd1 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) wa1 = wa0;
      if ($urandom_range(0, 7) == 0) wa0 = 5'd31;
      ra[4:0] = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom);
      ra[9:5] = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom);
      #1;
      check_all();
      tick();
    end
    reset = 1'b0;
    idle();
    #1;
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
